// File: rtl/alu_pkg.sv
// Shared datapath definitions for the ALU: opcode encodings, status bit
// positions and the default operand width.
package alu_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_NOT = 2'b11
    } alu_op_e;

    localparam int STAT_Z = 0;
    localparam int STAT_N = 1;
    localparam int STAT_V = 2;
    localparam int STAT_W = 3;

endpackage

// File: rtl/alu_status_reg.sv
// Three-bit status register with load enable; clears asynchronously on rst_n.
module alu_status_reg
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [STAT_W-1:0] stat_in,
    output logic [STAT_W-1:0] stat_out
);

    logic [STAT_W-1:0] stat_d;
    logic [STAT_W-1:0] stat_q;

    always_comb begin
        stat_d = stat_q;
        if (load) begin
            stat_d = stat_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_out = stat_q;

endmodule

// File: rtl/alu.sv
// Datapath ALU: combinational add/sub/and/not result plus registered
// zero/negative/overflow status captured when loads is high.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic [1:0]       ALUop,
    input  logic             loads,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       Z
);

    logic [WIDTH-1:0]  result;
    logic [STAT_W-1:0] stat_next;
    logic              a_msb;
    logic              b_msb;
    logic              r_msb;

    always_comb begin
        result = '0;
        unique case (alu_op_e'(ALUop))
            ALU_ADD: result = Ain + Bin;
            ALU_SUB: result = Ain + ~Bin + WIDTH'(1);
            ALU_AND: result = Ain & Bin;
            ALU_NOT: result = ~Bin;
        endcase
    end

    assign a_msb = Ain[WIDTH-1];
    assign b_msb = Bin[WIDTH-1];
    assign r_msb = result[WIDTH-1];

    // Overflow: operands whose effective signs agree produce a result of the other sign.
    always_comb begin
        stat_next         = '0;
        stat_next[STAT_Z] = (result == '0);
        stat_next[STAT_N] = r_msb;
        unique case (alu_op_e'(ALUop))
            ALU_ADD: stat_next[STAT_V] = (a_msb == b_msb) && (r_msb != a_msb);
            ALU_SUB: stat_next[STAT_V] = (a_msb != b_msb) && (r_msb != a_msb);
            ALU_AND: stat_next[STAT_V] = 1'b0;
            ALU_NOT: stat_next[STAT_V] = 1'b0;
        endcase
    end

    alu_status_reg u_status (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (loads),
        .stat_in  (stat_next),
        .stat_out (Z)
    );

    assign out = result;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: literal expectations per vector plus an
// arithmetic reference model compared against the DUT every cycle.
module tb_alu;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] Ain   = '0;
    logic [15:0] Bin   = '0;
    logic [1:0]  ALUop = '0;
    logic        loads = 1'b0;
    logic [15:0] out;
    logic [2:0]  Z;

    int   n_chk  = 0;
    int   n_pass = 0;
    bit   cmp_en = 1'b0;
    logic [2:0] z_m;

    alu #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Ain   (Ain),
        .Bin   (Bin),
        .ALUop (ALUop),
        .loads (loads),
        .out   (out),
        .Z     (Z)
    );

    always #5 clk = ~clk;

    // Reference result from integer arithmetic.
    function automatic logic [15:0] m_out(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] op);
        int r;
        case (op)
            2'd0:    r = int'(a) + int'(b);
            2'd1:    r = int'(a) - int'(b);
            2'd2:    r = int'(a & b);
            default: r = int'(~b);
        endcase
        return r[15:0];
    endfunction

    // Flags: overflow when the true signed result leaves the 16-bit range.
    function automatic logic [2:0] m_flags(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] op);
        int sa;
        int sb;
        int r;
        logic v;
        logic [15:0] o;
        sa = $signed(a);
        sb = $signed(b);
        v  = 1'b0;
        if (op == 2'd0) begin
            r = sa + sb;
            v = (r > 32767) || (r < -32768);
        end else if (op == 2'd1) begin
            r = sa - sb;
            v = (r > 32767) || (r < -32768);
        end
        o = m_out(a, b, op);
        return {v, o[15], (o == 16'h0000)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_m <= 3'b000;
        end else if (loads) begin
            z_m <= m_flags(Ain, Bin, ALUop);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            #2;
            chk("model_out", {16'h0, out}, {16'h0, m_out(Ain, Bin, ALUop)});
            chk("model_z", {29'h0, Z}, {29'h0, z_m});
        end
    end

    task automatic vec(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] op, input logic ld,
                       input logic [15:0] exp_out, input logic [2:0] exp_z);
        @(negedge clk);
        Ain   = a;
        Bin   = b;
        ALUop = op;
        loads = ld;
        #1;
        chk({name, "_out"}, {16'h0, out}, {16'h0, exp_out});
        @(posedge clk);
        #1;
        chk({name, "_z"}, {29'h0, Z}, {29'h0, exp_z});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_z", {29'h0, Z}, 32'h0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        vec("add",      16'h0001, 16'h0001, 2'b00, 1'b1, 16'h0002, 3'b000);
        vec("add_wrap", 16'hFFFF, 16'h0001, 2'b00, 1'b1, 16'h0000, 3'b001);
        vec("sub",      16'hFFFF, 16'h0001, 2'b01, 1'b1, 16'hFFFE, 3'b010);
        vec("and",      16'h2001, 16'h2001, 2'b10, 1'b1, 16'h2001, 3'b000);
        vec("not",      16'h0001, 16'h00DF, 2'b11, 1'b1, 16'hFF20, 3'b010);
        vec("not_ain",  16'hFFFF, 16'h00DF, 2'b11, 1'b1, 16'hFF20, 3'b010);
        vec("sub_zero", 16'h5A5A, 16'h5A5A, 2'b01, 1'b1, 16'h0000, 3'b001);
        vec("sub_ovf",  16'h8000, 16'h0001, 2'b01, 1'b1, 16'h7FFF, 3'b100);
        vec("add_neg2", 16'h8000, 16'h8000, 2'b00, 1'b1, 16'h0000, 3'b101);
        vec("and_zero", 16'hF0F0, 16'h0F0F, 2'b10, 1'b1, 16'h0000, 3'b001);
        vec("add_ovf",  16'h7FFF, 16'h0001, 2'b00, 1'b1, 16'h8000, 3'b110);

        // Hold: new operands with loads low leave the captured status alone.
        vec("hold1",    16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000, 3'b110);
        vec("hold2",    16'h1234, 16'h0004, 2'b01, 1'b0, 16'h1230, 3'b110);

        // Mid-cycle reset clears Z at once; out keeps following the operands.
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async_z", {29'h0, Z}, 32'h0);
        Ain   = 16'h1234;
        Bin   = 16'h1111;
        ALUop = 2'b00;
        loads = 1'b1;
        #1;
        chk("rst_out", {16'h0, out}, 32'h0000_2345);
        @(posedge clk);
        #1;
        chk("rst_hold_z", {29'h0, Z}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        vec("post_rst", 16'h7FFF, 16'h0001, 2'b00, 1'b1, 16'h8000, 3'b110);
        vec("post_add", 16'h0001, 16'h0001, 2'b00, 1'b1, 16'h0002, 3'b000);

        @(negedge clk);
        cmp_en = 1'b0;
        #3;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Arithmetic/logic unit of the RISC machine datapath. It combinationally computes a 16-bit result from two operands under a 2-bit opcode. It also captures zero, negative and overflow status flags into a clocked 3-bit status register for use by later branch and condition logic. The ALU sits between the operand-select muxes (Ain/Bin) and the result register.

## Interface
Parameters:
- WIDTH, 16, operand and result width in bits.

Ports:
- clk  input  1  single clock; the status register updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset for the status register.
- Ain  input  WIDTH  operand A.
- Bin  input  WIDTH  operand B.
- ALUop  input  2  operation select.
- loads  input  1  status-register load enable, sampled at the clk rising edge.
- out  output  WIDTH  combinational result.
- Z  output  3  registered status: Z[0] = zero, Z[1] = negative, Z[2] = signed overflow.

## Operation
- ALUop 2'b00: out = Ain + Bin, modulo 2^WIDTH. The carry-out is discarded.
- ALUop 2'b01: out = Ain − Bin, modulo 2^WIDTH, computed as Ain + ~Bin + 1.
- ALUop 2'b10: out = Ain & Bin, bitwise.
- ALUop 2'b11: out = ~Bin. Ain is ignored.
- Next-state flags are derived from out combinationally:
  - zero_n = (out == 0)
  - neg_n = out[WIDTH-1]
  - ovf_n for add: Ain[MSB] == Bin[MSB] and out[MSB] != Ain[MSB]
  - ovf_n for subtract: Ain[MSB] != Bin[MSB] and out[MSB] != Ain[MSB]
  - ovf_n = 0 for AND and NOT.
- Status register behaviour:
  - When loads = 1 at a clk rising edge, Z <= {ovf_n, neg_n, zero_n}.
  - When loads = 0, Z holds.
- There are no X-propagating paths. Every ALUop value is defined.

## Timing
- out has zero-cycle latency. It is purely combinational from Ain, Bin and ALUop, and is valid within the same delta/settle time with no clock required.
- Z has one-cycle latency. It reflects the operands/opcode present at the clk edge where loads = 1.
- Reset: rst_n low asserts Z = 3'b000 immediately, independent of clk. It has no effect on out.
- If reset is released coincident with a clk edge while loads = 1, Z remains 3'b000 for that edge. The first load occurs on the following edge.
- If operands change after a load, Z keeps the captured value until the next load.

## Structure
- The shared datapath package holds:
  - ALUop encodings: ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_NOT = 2'b11.
  - Status bit indices: STAT_Z = 0, STAT_N = 1, STAT_V = 2.
  - The WIDTH default.
- The natural sub-module is alu_status_reg: a 3-bit register with load enable and async active-low reset.
- The result logic is one combinational process in alu.

## Test plan
- Add: Ain = 0x0001, Bin = 0x0001, ALUop = 00 -> out = 0x0002. After load, Z = 3'b000.
- Add wrap-around: Ain = 0xFFFF, Bin = 0x0001, ALUop = 00 -> out = 0x0000. After load, Z = 3'b001 (zero set, no signed overflow).
- Subtract: Ain = 0xFFFF, Bin = 0x0001, ALUop = 01 -> out = 0xFFFE. After load, Z = 3'b010.
- AND and NOT:
  - Ain = 0x2001, Bin = 0x2001, ALUop = 10 -> out = 0x2001.
  - Ain = 0x0001, Bin = 0x00DF, ALUop = 11 -> out = 0xFF20, and Ain has no influence.
- Zero and overflow:
  - Ain = Bin = 0x5A5A, ALUop = 01 -> out = 0x0000, Z = 3'b001 after load.
  - Ain = 0x7FFF, Bin = 0x0001, ALUop = 00 -> out = 0x8000, Z = 3'b110 after load.
- Reset and hold:
  - Load Z = 3'b110, then drop loads and change operands -> Z unchanged.
  - Assert rst_n = 0 mid-cycle -> Z = 3'b000 immediately while out still tracks its inputs.
